// File: rtl/dm_arb_pkg.sv
// Shared definitions for the data-memory arbiter: state encoding, default widths
// and the counter-width helper used by the arbiter and its saturating counters.
package dm_arb_pkg;

  localparam int DEF_AW = 7;
  localparam int DEF_DW = 32;

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_BURST  = 2'd1,
    S_HALTED = 2'd2
  } arb_state_e;

  // Bits needed to hold values 0..limit; never less than one bit.
  function automatic int cnt_w(input int limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/arb_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module arb_sat_cnt
  import dm_arb_pkg::*;
#(
  parameter int LIMIT = 1,
  parameter int W     = cnt_w(LIMIT)
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         i_inc,
  input  logic         i_clr,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;
  logic         w_sat;

  assign w_sat = (r_cnt == W'(LIMIT));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && !w_sat) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/dm_arbiter.sv
// Shares the single-port data memory between the CPU MEM stage and the loader:
// one access per cycle, locked loader bursts, loader starvation guard, debug halt.
module dm_arbiter
  import dm_arb_pkg::*;
#(
  parameter int AW         = DEF_AW,
  parameter int DW         = DEF_DW,
  parameter int BURST_MAX  = 8,
  parameter int STARVE_LIM = 4
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_stall,
  output logic [DW-1:0] cpu_rdata,
  input  logic          ldr_req,
  input  logic          ldr_we,
  input  logic          ldr_lock,
  input  logic [AW-1:0] ldr_addr,
  input  logic [DW-1:0] ldr_wdata,
  output logic          ldr_gnt,
  output logic [DW-1:0] ldr_rdata,
  input  logic          dbg_halt,
  output logic          halt_ack,
  output logic          dm_we,
  output logic [AW-1:0] dm_addr,
  output logic [DW-1:0] dm_din,
  input  logic [DW-1:0] dm_dout
);

  localparam int BW = cnt_w(BURST_MAX);
  localparam int SW = cnt_w(STARVE_LIM);

  arb_state_e    r_state;
  arb_state_e    w_state_nxt;
  logic          r_force_cpu;
  logic          r_halt_ack;
  logic          w_force_nxt;
  logic          w_cpu_gnt;
  logic          w_ldr_gnt;
  logic [BW-1:0] w_burst_cnt;
  logic [SW-1:0] w_starve_cnt;
  logic          w_burst_last;
  logic          w_burst_clr;
  logic          w_starved;
  logic          w_starve_inc;
  logic          w_starve_clr;

  assign w_starved    = (w_starve_cnt == SW'(STARVE_LIM));
  assign w_burst_last = (w_burst_cnt == BW'(BURST_MAX - 1));

  always_comb begin
    w_cpu_gnt = 1'b0;
    w_ldr_gnt = 1'b0;
    case (r_state)
      S_HALTED: w_ldr_gnt = ldr_req;
      S_BURST: begin
        w_ldr_gnt = ldr_req;
        w_cpu_gnt = cpu_req & ~ldr_req;
      end
      default: begin
        // force_cpu overrides a saturated starvation count for one cycle after a full burst
        if (cpu_req && ldr_req) begin
          if (!r_force_cpu && w_starved) w_ldr_gnt = 1'b1;
          else                           w_cpu_gnt = 1'b1;
        end else begin
          w_cpu_gnt = cpu_req;
          w_ldr_gnt = ldr_req;
        end
      end
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_force_nxt = 1'b0;
    if (dbg_halt) begin
      w_state_nxt = S_HALTED;
    end else begin
      case (r_state)
        S_HALTED: w_state_nxt = S_RUN;
        S_BURST: begin
          if (w_ldr_gnt && w_burst_last) begin
            w_state_nxt = S_RUN;
            w_force_nxt = 1'b1;
          end else if (!ldr_lock) begin
            w_state_nxt = S_RUN;
          end
        end
        default: begin
          if (w_ldr_gnt && ldr_lock) begin
            if (BURST_MAX == 1) w_force_nxt = 1'b1;
            else                w_state_nxt = S_BURST;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= S_RUN;
      r_force_cpu <= 1'b0;
      r_halt_ack  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_force_cpu <= w_force_nxt;
      r_halt_ack  <= (w_state_nxt == S_HALTED);
    end
  end

  // The burst count is only meaningful while in BURST; any other next state zeroes it.
  assign w_burst_clr  = (w_state_nxt != S_BURST);
  assign w_starve_inc = ldr_req & ~w_ldr_gnt;
  assign w_starve_clr = ~ldr_req | w_ldr_gnt;

  arb_sat_cnt #(.LIMIT(BURST_MAX), .W(BW)) u_burst_cnt (
    .clk   (clk),
    .rstn  (rstn),
    .i_inc (w_ldr_gnt),
    .i_clr (w_burst_clr),
    .o_cnt (w_burst_cnt)
  );

  arb_sat_cnt #(.LIMIT(STARVE_LIM), .W(SW)) u_starve_cnt (
    .clk   (clk),
    .rstn  (rstn),
    .i_inc (w_starve_inc),
    .i_clr (w_starve_clr),
    .o_cnt (w_starve_cnt)
  );

  assign cpu_gnt   = w_cpu_gnt;
  assign ldr_gnt   = w_ldr_gnt;
  assign cpu_stall = cpu_req & ~w_cpu_gnt;
  assign halt_ack  = r_halt_ack;

  assign dm_we     = (w_cpu_gnt & cpu_we) | (w_ldr_gnt & ldr_we);
  assign dm_addr   = w_ldr_gnt ? ldr_addr  : cpu_addr;
  assign dm_din    = w_ldr_gnt ? ldr_wdata : cpu_wdata;
  assign cpu_rdata = dm_dout;
  assign ldr_rdata = dm_dout;

endmodule

// File: tb/tb_dm_arbiter.sv
// Bench for dm_arbiter: directed scenarios plus random traffic against a
// behavioural arbiter/memory model.
module tb_dm_arbiter;

  localparam int AW = 7;
  localparam int DW = 32;
  localparam int BM = 8;
  localparam int SL = 4;

  localparam int M_RUN   = 0;
  localparam int M_BURST = 1;
  localparam int M_HALT  = 2;

  logic          clk = 1'b0;
  logic          rstn;
  logic          cpu_req, cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_gnt, cpu_stall;
  logic [DW-1:0] cpu_rdata;
  logic          ldr_req, ldr_we, ldr_lock;
  logic [AW-1:0] ldr_addr;
  logic [DW-1:0] ldr_wdata;
  logic          ldr_gnt;
  logic [DW-1:0] ldr_rdata;
  logic          dbg_halt, halt_ack;
  logic          dm_we;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_din;
  logic [DW-1:0] dm_dout;

  dm_arbiter #(.AW(AW), .DW(DW), .BURST_MAX(BM), .STARVE_LIM(SL)) dut (
    .clk(clk), .rstn(rstn),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata),
    .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_lock(ldr_lock), .ldr_addr(ldr_addr),
    .ldr_wdata(ldr_wdata), .ldr_gnt(ldr_gnt), .ldr_rdata(ldr_rdata),
    .dbg_halt(dbg_halt), .halt_ack(halt_ack),
    .dm_we(dm_we), .dm_addr(dm_addr), .dm_din(dm_din), .dm_dout(dm_dout)
  );

  always #5 clk = ~clk;

  // Data memory attached to the DUT: combinational read, write at the clock edge.
  logic [DW-1:0] dm_mem [0:(1<<AW)-1];
  logic          mem_ready;
  assign dm_dout = dm_mem[dm_addr];
  always @(posedge clk) begin
    if (mem_ready !== 1'b1) begin
      for (int k = 0; k < (1<<AW); k++) dm_mem[k] <= 32'hC0DE0000 | DW'(k);
      mem_ready <= 1'b1;
    end else if (dm_we) begin
      dm_mem[dm_addr] <= dm_din;
    end
  end

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  int  m_mode, m_burst, m_starve;
  bit  m_force;
  bit  e_cpu, e_ldr;
  bit  obs_cpu, obs_ldr, obs_we, obs_stall, obs_ack;
  logic [DW-1:0] obs_cpu_rd, obs_ldr_rd;
  bit  cpu_done, ldr_done;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = M_RUN; m_burst = 0; m_starve = 0; m_force = 0;
  endtask

  // Asynchronous reset pulse placed mid-cycle, just after the falling edge.
  task automatic reset_pulse();
    #1 rstn = 1'b0;
    #1 rstn = 1'b1;
    model_reset();
  endtask

  // Called right after inputs are driven at a falling edge; ends at the next falling edge.
  task automatic step();
    bit e_we;
    int n_mode, n_burst, n_starve;
    bit n_force;
    logic [AW-1:0] w_a;
    logic [DW-1:0] w_d;
    #2;
    e_cpu = 0; e_ldr = 0;
    if (m_mode == M_HALT) begin
      e_ldr = ldr_req;
    end else if (m_mode == M_BURST) begin
      e_ldr = ldr_req;
      e_cpu = cpu_req && !ldr_req;
    end else if (cpu_req && ldr_req) begin
      if (!m_force && m_starve >= SL) e_ldr = 1;
      else                            e_cpu = 1;
    end else begin
      e_cpu = cpu_req;
      e_ldr = ldr_req;
    end
    e_we = (e_cpu && cpu_we) || (e_ldr && ldr_we);
    w_a  = e_ldr ? ldr_addr : cpu_addr;
    w_d  = e_ldr ? ldr_wdata : cpu_wdata;

    obs_cpu = cpu_gnt; obs_ldr = ldr_gnt; obs_we = dm_we;
    obs_stall = cpu_stall; obs_ack = halt_ack;
    obs_cpu_rd = cpu_rdata; obs_ldr_rd = ldr_rdata;

    chk("ctl{cg,lg,stall,we,ack}", {cpu_gnt, ldr_gnt, cpu_stall, dm_we, halt_ack},
        {e_cpu, e_ldr, cpu_req && !e_cpu, e_we, m_mode == M_HALT});
    chk("dm_addr", dm_addr, w_a);
    if (e_we) chk("dm_din", dm_din, w_d);
    if (e_cpu && !cpu_we) chk("cpu_rdata", cpu_rdata, ref_mem[cpu_addr]);
    if (e_ldr && !ldr_we) chk("ldr_rdata", ldr_rdata, ref_mem[ldr_addr]);

    n_mode = m_mode; n_burst = m_burst; n_force = 0;
    if (dbg_halt) begin
      n_mode = M_HALT; n_burst = 0;
    end else if (m_mode == M_HALT) begin
      n_mode = M_RUN;
    end else if (m_mode == M_RUN) begin
      if (e_ldr && ldr_lock) begin
        if (BM == 1) n_force = 1;
        else begin n_mode = M_BURST; n_burst = 1; end
      end
    end else begin
      if (e_ldr) n_burst = m_burst + 1;
      if (n_burst == BM) begin n_mode = M_RUN; n_burst = 0; n_force = 1; end
      else if (!ldr_lock) begin n_mode = M_RUN; n_burst = 0; end
    end
    n_starve = (ldr_req && !e_ldr) ? ((m_starve + 1 > SL) ? SL : m_starve + 1) : 0;

    @(posedge clk);
    m_mode = n_mode; m_burst = n_burst; m_force = n_force; m_starve = n_starve;
    if (e_we) ref_mem[w_a] = w_d;
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    ldr_req = 0; ldr_we = 0; ldr_lock = 0; ldr_addr = '0; ldr_wdata = '0;
    dbg_halt = 0;
  endtask

  initial begin
    int nl, run, maxrun;
    for (int k = 0; k < (1<<AW); k++) ref_mem[k] = 32'hC0DE0000 | DW'(k);
    idle_inputs();
    rstn = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    rstn = 1'b1;

    // Reset / idle
    reset_pulse();
    step();
    chk("t1_idle", {obs_cpu, obs_ldr, obs_we, obs_ack}, 4'b0000);
    step();
    cpu_req = 1; ldr_req = 1; cpu_addr = 7'd3; ldr_addr = 7'd4;
    step();
    chk("t1_run_cpu_first", obs_cpu, 1);

    // Contention without lock: CPU x4, loader x1
    reset_pulse();
    nl = 0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (obs_ldr) nl++;
      if (c == 4) chk("t2_stall_in_ldr_cycle", obs_stall, 1);
    end
    chk("t2_ldr_grants", nl, 2);

    // Locked burst writes addr 0..7
    reset_pulse();
    ldr_lock = 1; ldr_we = 1; ldr_addr = 7'd0; ldr_wdata = 32'hA0000000;
    cpu_addr = 7'd100;
    nl = 0; run = 0; maxrun = 0;
    for (int c = 0; c < 40 && nl < 8; c++) begin
      step();
      if (obs_ldr) begin
        nl++; run++;
        if (run > maxrun) maxrun = run;
        ldr_addr = AW'(nl); ldr_wdata = 32'hA0000000 + DW'(nl);
      end else run = 0;
    end
    chk("t3_burst_len", maxrun, 8);
    step();
    chk("t3_force_cpu", obs_cpu, 1);
    cpu_req = 0; ldr_lock = 0; ldr_we = 0;
    for (int k = 0; k < 8; k++) begin
      ldr_addr = AW'(k);
      step();
      chk("t3_readback", obs_ldr_rd, 32'hA0000000 + DW'(k));
    end

    // Early lock release
    reset_pulse();
    cpu_req = 1; ldr_req = 1; ldr_lock = 1; ldr_we = 0;
    nl = 0;
    for (int c = 0; c < 40 && nl < 3; c++) begin
      step();
      if (obs_ldr) nl++;
    end
    ldr_lock = 0;
    step();
    chk("t4_last_ldr", obs_ldr, 1);
    step();
    chk("t4_cpu_after_release", obs_cpu, 1);

    // Debug halt
    reset_pulse();
    idle_inputs();
    dbg_halt = 1;
    step();
    cpu_req = 1; cpu_we = 1; cpu_addr = 7'd5; cpu_wdata = 32'hDEADBEEF;
    ldr_req = 1; ldr_we = 1; ldr_addr = 7'd5; ldr_wdata = 32'h12345678;
    step();
    chk("t5_halt_ack", obs_ack, 1);
    chk("t5_ldr_in_halt", {obs_ldr, obs_stall}, 2'b11);
    ldr_req = 0;
    step();
    chk("t5_no_cpu_we", obs_we, 0);
    dbg_halt = 0;
    step();
    chk("t5_still_stalled", obs_stall, 1);
    step();
    chk("t5_cpu_store", {obs_cpu, obs_we, obs_ack}, 3'b110);
    cpu_we = 0;
    step();
    chk("t5_readback", obs_cpu_rd, 32'hDEADBEEF);

    // Reset in the middle of a burst
    reset_pulse();
    idle_inputs();
    cpu_req = 1; ldr_req = 1; ldr_lock = 1;
    nl = 0;
    for (int c = 0; c < 40 && nl < 5; c++) begin
      step();
      if (obs_ldr) nl++;
    end
    reset_pulse();
    step();
    chk("t6_cpu_after_reset", {obs_cpu, obs_ldr}, 2'b10);

    // Random traffic
    idle_inputs();
    cpu_done = 1; ldr_done = 1;
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 63) == 0) reset_pulse();
      if ($urandom_range(0, 29) == 0) dbg_halt = ~dbg_halt;
      if (!cpu_req || cpu_done) begin
        cpu_req = ($urandom_range(0, 3) != 0);
        cpu_we = $urandom_range(0, 1) == 1;
        cpu_addr = AW'($urandom_range(0, 15));
        cpu_wdata = $urandom;
      end else if ($urandom_range(0, 15) == 0) cpu_req = 0;
      if (!ldr_req || ldr_done) begin
        ldr_req = ($urandom_range(0, 2) != 0);
        ldr_we = $urandom_range(0, 1) == 1;
        ldr_addr = AW'($urandom_range(0, 15));
        ldr_wdata = $urandom;
      end else if ($urandom_range(0, 15) == 0) ldr_req = 0;
      ldr_lock = ($urandom_range(0, 3) != 0);
      step();
      cpu_done = e_cpu; ldr_done = e_ldr;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dm_arbiter.md
Name: dm_arbiter

Overview:
Two-requester arbiter that shares the single-port data memory (dm) between the pipelined CPU's MEM stage and a debug/program loader.
- Sits between the plcpu data port and the dm instance in the CPU top.
- Grants one access per cycle and stalls the CPU when it loses.
- Supports locked loader bursts, starvation protection for the loader, and a debug halt handshake that freezes CPU memory traffic.

Parameters:
AW, 7, dm word-address width (byte address bits [8:2])
DW, 32, data width
BURST_MAX, 8, maximum consecutive loader grants while ldr_lock is high (≥1)
STARVE_LIM, 4, waiting cycles after which the loader beats the CPU (≥1)

Ports:
clk  in  1  clock, rising edge
rstn  in  1  reset; one clock; reset is asynchronous and active-low
cpu_req  in  1  CPU MEM-stage load/store request
cpu_we  in  1  CPU store
cpu_addr  in  AW  CPU word address
cpu_wdata  in  DW  CPU store data
cpu_gnt  out  1  CPU access performed this cycle
cpu_stall  out  1  cpu_req & ~cpu_gnt; freezes the pipeline
cpu_rdata  out  DW  load data (dm_dout passthrough)
ldr_req  in  1  loader request
ldr_we  in  1  loader write
ldr_lock  in  1  loader requests burst ownership
ldr_addr  in  AW  loader word address
ldr_wdata  in  DW  loader write data
ldr_gnt  out  1  loader access performed this cycle
ldr_rdata  out  DW  read data (dm_dout passthrough)
dbg_halt  in  1  debug request to halt CPU memory traffic
halt_ack  out  1  CPU memory traffic halted
dm_we  out  1  to dm DMWr
dm_addr  out  AW  to dm addr
dm_din  out  DW  to dm din
dm_dout  in  DW  from dm dout (combinational read)

Behaviour:
- **Access timing:** dm reads are combinational, so an access completes in the cycle it is granted.
  - Grants are combinational from the registered state plus the current requests.
  - Writes commit at the clk edge that ends the grant cycle.
- **Datapath mux:**
  - dm_addr/dm_din come from the granted requester; they are the CPU's when nothing is granted.
  - dm_we = (cpu_gnt & cpu_we) | (ldr_gnt & ldr_we), so there is never a write without a grant.
  - cpu_gnt and ldr_gnt are never both 1.
- **State machine (registered):** states RUN, BURST, HALTED.
- **RUN arbitration:**
  - cpu_req only → CPU.
  - ldr_req only → loader.
  - Both → loader if starve_cnt == STARVE_LIM, else CPU.
- **RUN exits:**
  - Loader granted with ldr_lock=1 → BURST, burst_cnt=1.
  - When BURST_MAX=1 the burst ends immediately: stay RUN and set force_cpu.
- **BURST arbitration:** the loader wins whenever ldr_req; the CPU is served only in cycles with ldr_req=0.
- **BURST counting:** each loader grant increments burst_cnt.
- **BURST exits:**
  - Exit to RUN when ldr_lock=0 is sampled.
  - Exit to RUN after the grant that makes burst_cnt == BURST_MAX.
  - On exit, burst_cnt is cleared.
  - On a BURST_MAX exit, force_cpu is set for the next cycle: CPU wins if it requests, even if starve_cnt is saturated. force_cpu clears after one cycle.
- **HALTED:**
  - Entered from any state on the edge after dbg_halt=1 is sampled; this takes priority over burst transitions and clears burst_cnt.
  - cpu_gnt=0, so a requesting CPU sees cpu_stall=1.
  - Loader is granted whenever ldr_req; ldr_lock is ignored.
  - halt_ack=1 exactly while in HALTED (registered).
  - Exit to RUN on the edge after dbg_halt=0 is sampled; halt_ack drops that edge.
- **Starvation counter:**
  - starve_cnt increments (saturating at STARVE_LIM) each cycle with ldr_req & ~ldr_gnt.
  - Clears on ldr_gnt or when ldr_req=0.
- **Reset (async, rstn=0):**
  - state=RUN, burst_cnt=0, starve_cnt=0, force_cpu=0, halt_ack=0.
  - Grants and dm_we follow the combinational rules, so they are 0 with no requests.
  - A reset mid-burst or mid-halt returns immediately to RUN.
- **Request rules:**
  - Requests must hold address, data and we stable until granted.
  - A requester dropping req before its grant is legal and produces no access.
- **Deadlock freedom:**
  - CPU waits at most BURST_MAX cycles when not halted.
  - Loader waits at most STARVE_LIM+1 cycles.

Decomposition:
- Shared package dm_arb_pkg holds:
  - state encoding constants S_RUN, S_BURST, S_HALTED;
  - default AW/DW.
- One natural sub-module, arb_sat_cnt: a parameterised saturating counter with inc/clr/limit. It is instantiated twice, for burst_cnt and starve_cnt.
- Datapath mux and FSM stay in dm_arbiter.

Test Plan:
1. Reset/idle: rstn pulsed low mid-cycle, no requests → all grants, dm_we and halt_ack are 0; state RUN.
2. Contention: cpu_req and ldr_req held high, ldr_lock=0, STARVE_LIM=4.
   - Required grant sequence: CPU×4, loader×1, repeating.
   - cpu_stall=1 only in the loader cycles.
3. Burst: ldr_lock=1, ldr_req high, cpu_req high, BURST_MAX=8.
   - Loader gets 8 consecutive grants, then CPU gets 1 (force_cpu), then arbitration resumes.
   - Writes to addr 0..7 read back correctly.
4. Burst early release: ldr_lock dropped after 3 grants → state back to RUN; CPU wins the next contended cycle.
5. Halt:
   - dbg_halt=1 → halt_ack=1 next cycle.
   - CPU store to addr 5 with data 0xDEADBEEF stalls with no dm_we.
   - Loader writes addr 5 = 0x12345678.
   - dbg_halt=0 → CPU store completes; readback shows 0xDEADBEEF.
6. Reset mid-burst: rstn low during burst_cnt=5 → on release, state RUN and burst_cnt=0; CPU wins the first contended cycle.
